// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the architectural PC, fetches one word per step over a
// valid/ready memory port, hands it to execute, then follows dnpc or halts.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        imem_resp_ready,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic        exec_done,
    input  logic [31:0] dnpc,
    input  logic        halt,
    output logic        halted,
    output logic        misaligned,
    output logic [31:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_EXEC,
        S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic        halted_q, halted_d;
    logic        misaligned_q, misaligned_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            retire_cnt_q <= '0;
            halted_q     <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            retire_cnt_q <= retire_cnt_d;
            halted_q     <= halted_d;
            misaligned_q <= misaligned_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        retire_cnt_d = retire_cnt_q;
        halted_d     = halted_q;
        misaligned_d = misaligned_q;

        unique case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    inst_d  = imem_resp_data;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    retire_cnt_d = retire_cnt_q + 32'd1;
                    if (halt) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else if (dnpc[1:0] != 2'b00) begin
                        halted_d     = 1'b1;
                        misaligned_d = 1'b1;
                        state_d      = S_HALT;
                    end else begin
                        pc_d    = dnpc;
                        state_d = S_REQ;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Handshake outputs are forced low while reset is asserted, whatever state is held.
    assign imem_req_valid  = !rst && (state_q == S_REQ);
    assign imem_resp_ready = !rst && (state_q == S_WAIT);
    assign inst_valid      = !rst && (state_q == S_HOLD);
    assign imem_req_addr   = pc_q;
    assign pc              = pc_q;
    assign inst            = inst_q;
    assign halted          = halted_q;
    assign misaligned      = misaligned_q;
    assign retire_cnt      = retire_cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a cycle-by-cycle vector table followed by hand-written
// sequences for the halt-absorbing and HOLD/EXEC boundary cases.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_ready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        exec_done;
    logic [31:0] dnpc;
    logic        halt;
    logic        halted;
    logic        misaligned;
    logic [31:0] retire_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_ready (imem_resp_ready),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .pc              (pc),
        .exec_done       (exec_done),
        .dnpc            (dnpc),
        .halt            (halt),
        .halted          (halted),
        .misaligned      (misaligned),
        .retire_cnt      (retire_cnt)
    );

    typedef struct {
        logic        rst;
        logic        rq_rdy;
        logic        rs_vld;
        logic [31:0] rs_data;
        logic        i_rdy;
        logic        ex_done;
        logic [31:0] dnpc;
        logic        halt;
        logic        e_rv;
        logic        e_rr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_h;
        logic        e_m;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rqr, input logic rsv, input logic [31:0] rsd,
                       input logic ir, input logic ed, input logic [31:0] np, input logic hl,
                       input logic erv, input logic err, input logic eiv, input logic [31:0] ein,
                       input logic [31:0] epc, input logic eh, input logic em,
                       input logic [31:0] ecnt);
        vec_t v;
        v.rst = r; v.rq_rdy = rqr; v.rs_vld = rsv; v.rs_data = rsd;
        v.i_rdy = ir; v.ex_done = ed; v.dnpc = np; v.halt = hl;
        v.e_rv = erv; v.e_rr = err; v.e_iv = eiv; v.e_inst = ein;
        v.e_pc = epc; v.e_h = eh; v.e_m = em; v.e_cnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic rqr, input logic rsv, input logic [31:0] rsd,
                         input logic ir, input logic ed, input logic [31:0] np, input logic hl);
        rst = r; imem_req_ready = rqr; imem_resp_valid = rsv; imem_resp_data = rsd;
        inst_ready = ir; exec_done = ed; dnpc = np; halt = hl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        seen_req;
        logic        got;
        logic [159:0] act;
        logic [159:0] exp;

        // Each vector: inputs for this cycle, and outputs expected before the next edge.
        //  rst rqr rsv rs_data        ir ed dnpc           hl | rv rr iv inst           pc             h  m  cnt
        add(1, 0, 0, 32'h0,          0, 0, 32'h0,         0,   0, 0, 0, 32'h0,        32'h8000_0000, 0, 0, 0); // v0 reset
        add(0, 1, 0, 32'h0,          0, 0, 32'h0,         0,   1, 0, 0, 32'h0,        32'h8000_0000, 0, 0, 0); // v1 REQ accepted
        add(0, 0, 1, 32'h0050_0093,  0, 0, 32'h0,         0,   0, 1, 0, 32'h0,        32'h8000_0000, 0, 0, 0); // v2 WAIT resp
        add(0, 0, 0, 32'h0,          1, 0, 32'h0,         0,   0, 0, 1, 32'h0050_0093,32'h8000_0000, 0, 0, 0); // v3 HOLD
        add(0, 0, 0, 32'h0,          0, 1, 32'h8000_0010, 0,   0, 0, 0, 32'h0050_0093,32'h8000_0000, 0, 0, 0); // v4 EXEC done
        add(0, 0, 0, 32'h0,          0, 0, 32'h0,         0,   1, 0, 0, 32'h0050_0093,32'h8000_0010, 0, 0, 1); // v5 req stalled
        add(0, 0, 0, 32'h0,          0, 0, 32'h0,         0,   1, 0, 0, 32'h0050_0093,32'h8000_0010, 0, 0, 1); // v6
        add(0, 0, 0, 32'h0,          0, 0, 32'h0,         0,   1, 0, 0, 32'h0050_0093,32'h8000_0010, 0, 0, 1); // v7
        add(0, 1, 0, 32'h0,          0, 0, 32'h0,         0,   1, 0, 0, 32'h0050_0093,32'h8000_0010, 0, 0, 1); // v8 accepted
        add(0, 0, 0, 32'h0,          0, 0, 32'h0,         0,   0, 1, 0, 32'h0050_0093,32'h8000_0010, 0, 0, 1); // v9 no resp yet
        add(0, 0, 1, 32'h0000_0013,  0, 0, 32'h0,         0,   0, 1, 0, 32'h0050_0093,32'h8000_0010, 0, 0, 1); // v10 resp
        add(0, 0, 0, 32'h0,          0, 1, 32'h8000_0040, 0,   0, 0, 1, 32'h0000_0013,32'h8000_0010, 0, 0, 1); // v11 HOLD, done ignored
        add(0, 0, 0, 32'h0,          0, 1, 32'h8000_0040, 0,   0, 0, 1, 32'h0000_0013,32'h8000_0010, 0, 0, 1); // v12
        add(0, 0, 0, 32'h0,          0, 0, 32'h0,         0,   0, 0, 1, 32'h0000_0013,32'h8000_0010, 0, 0, 1); // v13
        add(0, 0, 0, 32'h0,          0, 0, 32'h0,         0,   0, 0, 1, 32'h0000_0013,32'h8000_0010, 0, 0, 1); // v14
        add(0, 0, 0, 32'h0,          1, 0, 32'h0,         0,   0, 0, 1, 32'h0000_0013,32'h8000_0010, 0, 0, 1); // v15 consumed
        add(0, 0, 0, 32'h0,          0, 0, 32'h0,         0,   0, 0, 0, 32'h0000_0013,32'h8000_0010, 0, 0, 1); // v16 EXEC idle
        add(0, 0, 0, 32'h0,          0, 1, 32'h8000_0012, 0,   0, 0, 0, 32'h0000_0013,32'h8000_0010, 0, 0, 1); // v17 misaligned dnpc
        add(0, 1, 1, 32'h1234_5678,  1, 0, 32'h0,         0,   0, 0, 0, 32'h0000_0013,32'h8000_0010, 1, 1, 2); // v18 HALT
        add(0, 0, 0, 32'h0,          0, 1, 32'h8000_0000, 0,   0, 0, 0, 32'h0000_0013,32'h8000_0010, 1, 1, 2); // v19 done ignored
        add(1, 0, 0, 32'h0,          0, 0, 32'h0,         0,   0, 0, 0, 32'h0000_0013,32'h8000_0010, 1, 1, 2); // v20 reset from HALT
        add(0, 1, 0, 32'h0,          0, 0, 32'h0,         0,   1, 0, 0, 32'h0,        32'h8000_0000, 0, 0, 0); // v21 REQ accepted
        add(1, 0, 0, 32'h0,          0, 0, 32'h0,         0,   0, 0, 0, 32'h0,        32'h8000_0000, 0, 0, 0); // v22 reset in WAIT
        add(0, 0, 1, 32'hDEAD_BEEF,  0, 0, 32'h0,         0,   1, 0, 0, 32'h0,        32'h8000_0000, 0, 0, 0); // v23 stale resp
        add(0, 1, 0, 32'h0,          0, 0, 32'h0,         0,   1, 0, 0, 32'h0,        32'h8000_0000, 0, 0, 0); // v24 refetch
        add(0, 0, 1, 32'h0050_0093,  0, 0, 32'h0,         0,   0, 1, 0, 32'h0,        32'h8000_0000, 0, 0, 0); // v25 resp
        add(0, 0, 0, 32'h0,          1, 0, 32'h0,         0,   0, 0, 1, 32'h0050_0093,32'h8000_0000, 0, 0, 0); // v26 HOLD
        add(0, 0, 0, 32'h0,          0, 1, 32'h8000_0013, 1,   0, 0, 0, 32'h0050_0093,32'h8000_0000, 0, 0, 0); // v27 ebreak
        add(0, 0, 0, 32'h0,          0, 0, 32'h0,         0,   0, 0, 0, 32'h0050_0093,32'h8000_0000, 1, 0, 1); // v28 HALT, not misaligned

        drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].rq_rdy, vecs[i].rs_vld, vecs[i].rs_data,
                  vecs[i].i_rdy, vecs[i].ex_done, vecs[i].dnpc, vecs[i].halt);
            #1;
            act = {27'd0, imem_req_valid, imem_req_addr, imem_resp_ready, inst_valid, inst, pc,
                   halted, misaligned, retire_cnt};
            exp = {27'd0, vecs[i].e_rv, vecs[i].e_pc, vecs[i].e_rr, vecs[i].e_iv, vecs[i].e_inst,
                   vecs[i].e_pc, vecs[i].e_h, vecs[i].e_m, vecs[i].e_cnt};
            check($sformatf("vec%0d", i), act, exp);
            step();
        end

        // HALT absorbs everything for 20 cycles: no request, no ready/valid, state frozen.
        seen_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            drive(0, 1, 1, 32'hFFFF_FFFF, 1, 1, 32'h8000_0100, c[0]);
            #1;
            if (imem_req_valid || imem_resp_ready || inst_valid || !halted || misaligned ||
                retire_cnt != 32'd1 || pc != 32'h8000_0000)
                seen_req = 1'b1;
            step();
        end
        check("halt_absorbing", {159'd0, seen_req}, 160'd0);

        // exec_done coincident with the HOLD->EXEC handshake must not retire.
        drive(1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        step();
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        got = 1'b0;
        for (int c = 0; c < 5 && !got; c++) begin
            #1;
            if (imem_req_valid) got = 1'b1;
            else step();
        end
        check("req_after_reset", {159'd0, got}, {159'd0, 1'b1});
        drive(0, 1, 0, 32'h0, 0, 0, 32'h0, 0);
        step();
        drive(0, 0, 1, 32'hABCD_0001, 0, 0, 32'h0, 0);
        step();
        drive(0, 0, 0, 32'h0, 1, 1, 32'h8000_0100, 0);
        #1;
        check("hold_inst", {128'd0, inst}, {128'd0, 32'hABCD_0001});
        step();
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        #1;
        check("exec_no_early_retire", {95'd0, imem_req_valid, inst_valid, retire_cnt, pc},
              {95'd0, 1'b0, 1'b0, 32'd0, 32'h8000_0000});
        drive(0, 0, 0, 32'h0, 0, 1, 32'h8000_0100, 0);
        step();
        drive(0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        #1;
        check("next_fetch", {94'd0, imem_req_valid, halted, imem_req_addr, retire_cnt},
              {94'd0, 1'b1, 1'b0, 32'h8000_0100, 32'd1});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
